// File: rtl/float_copro_arbiter_if.sv
// Requester and float-unit channels of the float coprocessor arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface float_copro_arbiter_if #(
  parameter int W = 32
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [3:0]     req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           fu_start;
  logic [1:0]     fu_op;
  logic [W-1:0]   fu_a;
  logic [W-1:0]   fu_b;
  logic           fu_done;
  logic [W-1:0]   fu_result;

  modport slave (
    input  req_valid, req_op, req_a, req_b, fu_done, fu_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, fu_start, fu_op, fu_a, fu_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, fu_done, fu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, fu_start, fu_op, fu_a, fu_b
  );
endinterface

// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one multicycle float unit between two requesters,
// with a done-timeout watchdog and a one-cycle response to the originator.
module float_copro_arbiter #(
  parameter int NE      = 8,
  parameter int NM      = 23,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset_n,
  float_copro_arbiter_if.slave bus,
  output logic                 busy
);
  localparam int W  = 1 + NE + NM;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t         state_r;
  logic           last_grant_r;
  logic           id_r;
  logic [TW-1:0]  timer_r;
  logic           fu_start_r;
  logic [1:0]     fu_op_r;
  logic [W-1:0]   fu_a_r;
  logic [W-1:0]   fu_b_r;
  logic [1:0]     rsp_valid_r;
  logic [W-1:0]   rsp_result_r;
  logic           rsp_err_r;
  logic           busy_r;

  logic [1:0]     grant_s;
  logic [1:0]     req_ready_s;
  logic [1:0]     sel_op_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;

  // Grant: a lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant_s = 2'b00;
    case (bus.req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  // Ready is only offered in IDLE outside reset; operand mux follows the grant.
  always_comb begin
    req_ready_s = 2'b00;
    sel_op_s    = 2'b00;
    sel_a_s     = {W{1'b0}};
    sel_b_s     = {W{1'b0}};
    if ((state_r == IDLE) && reset_n) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = 2'b00;
    end
    if (grant_s[1]) begin
      sel_op_s = bus.req_op[3:2];
      sel_a_s  = bus.req_a[2*W-1:W];
      sel_b_s  = bus.req_b[2*W-1:W];
    end else begin
      sel_op_s = bus.req_op[1:0];
      sel_a_s  = bus.req_a[W-1:0];
      sel_b_s  = bus.req_b[W-1:0];
    end
  end

  // Command FSM; every output is a register updated on the state transition into it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      timer_r      <= {TW{1'b0}};
      fu_start_r   <= 1'b0;
      fu_op_r      <= 2'b00;
      fu_a_r       <= {W{1'b0}};
      fu_b_r       <= {W{1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_result_r <= {W{1'b0}};
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_ready_s) begin
            id_r       <= grant_s[1];
            fu_op_r    <= sel_op_s;
            fu_a_r     <= sel_a_s;
            fu_b_r     <= sel_b_s;
            fu_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          fu_start_r <= 1'b0;
          timer_r    <= {TW{1'b0}};
          state_r    <= WAIT;
        end
        WAIT: begin
          // A done pulse in the final watchdog cycle still wins over the timeout.
          if (bus.fu_done || (timer_r == TW'(TIMEOUT))) begin
            rsp_result_r <= bus.fu_done ? bus.fu_result : {W{1'b0}};
            rsp_err_r    <= ~bus.fu_done;
            rsp_valid_r  <= id_r ? 2'b10 : 2'b01;
            fu_op_r      <= 2'b00;
            fu_a_r       <= {W{1'b0}};
            fu_b_r       <= {W{1'b0}};
            state_r      <= RESP;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RESP: begin
          rsp_valid_r  <= 2'b00;
          rsp_result_r <= {W{1'b0}};
          rsp_err_r    <= 1'b0;
          busy_r       <= 1'b0;
          last_grant_r <= id_r;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.fu_start   = fu_start_r;
  assign bus.fu_op      = fu_op_r;
  assign bus.fu_a       = fu_a_r;
  assign bus.fu_b       = fu_b_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_err    = rsp_err_r;
  assign busy           = busy_r;
endmodule

// File: tb/tb_float_copro_arbiter.sv
// Scoreboard bench for float_copro_arbiter: a latency-programmable unit model,
// expected responses queued at stimulus time and popped on rsp_valid.
module tb_float_copro_arbiter;
  localparam int NE = 8;
  localparam int NM = 23;
  localparam int W = 32;
  localparam int TIMEOUT = 63;
  localparam logic [31:0] F1_0 = 32'h3F800000;
  localparam logic [31:0] F1_5 = 32'h3FC00000;
  localparam logic [31:0] F2_0 = 32'h40000000;
  localparam logic [31:0] F3_0 = 32'h40400000;

  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   rsp_cyc = -1;
  int   fu_lat = 3;
  bit   fu_stuck = 1'b0;
  int   done_at = -1;
  int   cnt = 0;
  logic [W-1:0] fu_val = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  float_copro_arbiter_if #(.W(W)) bus ();

  float_copro_arbiter #(.NE(NE), .NM(NM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] res, input logic err);
    exp_t e;
    e.id = id; e.op = op; e.a = a; e.b = b; e.res = res; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int n0, input int budget);
    int n = 0;
    while (rsp_count == n0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (rsp_count == n0) check_eq("rsp_wait_expired", 0, 1);
  endtask

  // Float unit model plus response monitor, both evaluated on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bus.fu_done = 1'b0;
    if (bus.fu_start) begin
      if (sb.size() > 0) begin
        check_eq("fu_op", bus.fu_op, sb[0].op);
        check_eq("fu_a", bus.fu_a, sb[0].a);
        check_eq("fu_b", bus.fu_b, sb[0].b);
        fu_val = sb[0].res;
      end else begin
        check_eq("fu_start_unexpected", 1, 0);
      end
      cnt = fu_stuck ? 0 : fu_lat;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.fu_done = 1'b1;
        bus.fu_result = fu_val;
      end
    end
    if (cyc == done_at) begin
      bus.fu_done = 1'b1;
      bus.fu_result = fu_val;
    end
    if (|bus.rsp_valid) begin
      rsp_cyc = cyc;
      rsp_count++;
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_valid", bus.rsp_valid, e.id ? 2'b10 : 2'b01);
        check_eq("rsp_result", bus.rsp_result, e.res);
        check_eq("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    int c0;
    int n0;
    int n;
    // Reset with both requesters already valid: outputs must stay 0.
    bus.req_valid = 2'b11;
    bus.req_op = {2'b01, 2'b00};
    bus.req_a = {F3_0, F1_0};
    bus.req_b = {F1_0, F1_0};
    repeat (2) @(negedge clk);
    check_eq("rst_ready", bus.req_ready, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_fu_start", bus.fu_start, 1'b0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check_eq("rst_fu_a", bus.fu_a, 0);

    // Contention: req0 first, then strict alternation over six commands.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(1'b0, 2'b00, F1_0, F1_0, F2_0, 1'b0);
      else            push(1'b1, 2'b01, F3_0, F1_0, F2_0, 1'b0);
    end
    n0 = rsp_count;
    reset_n = 1'b1;
    #1;
    check_eq("contend_first_grant", bus.req_ready, 2'b01);
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    bus.req_valid = 2'b00;
    check_eq("contend_count", rsp_count - n0, 6);
    sb.delete();

    // Single mul, k=3.
    @(negedge clk);
    c0 = cyc; n0 = rsp_count; fu_stuck = 1'b0; fu_lat = 3;
    bus.req_op[1:0] = 2'b10; bus.req_a[W-1:0] = F1_5; bus.req_b[W-1:0] = F2_0;
    bus.req_valid = 2'b01;
    push(1'b0, 2'b10, F1_5, F2_0, F3_0, 1'b0);
    #1;
    check_eq("mul_ready", bus.req_ready, 2'b01);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin
        bus.req_valid = 2'b00;
        check_eq("mul_fu_start", bus.fu_start, 1'b1);
      end
      check_eq("mul_busy", busy, (i <= 5) ? 1'b1 : 1'b0);
    end
    check_eq("mul_rsp_count", rsp_count, n0 + 1);
    check_eq("mul_rsp_cycle", rsp_cyc, c0 + 5);

    // Stuck unit: watchdog response, then a stray done in IDLE is ignored.
    @(negedge clk);
    c0 = cyc; n0 = rsp_count; fu_stuck = 1'b1;
    bus.req_op[1:0] = 2'b00; bus.req_a[W-1:0] = F1_0; bus.req_b[W-1:0] = F2_0;
    bus.req_valid = 2'b01;
    push(1'b0, 2'b00, F1_0, F2_0, 32'h0, 1'b1);
    @(negedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(n0, 100);
    check_eq("timeout_cycle", rsp_cyc, c0 + TIMEOUT + 3);
    done_at = cyc + 2;
    repeat (5) @(negedge clk);
    #1;
    check_eq("idle_done_ignored", rsp_count, n0 + 1);

    // Done in the very last watchdog cycle wins over the timeout.
    @(negedge clk);
    c0 = cyc; n0 = rsp_count; fu_stuck = 1'b1; done_at = c0 + TIMEOUT + 2;
    bus.req_op[3:2] = 2'b10; bus.req_a[2*W-1:W] = F2_0; bus.req_b[2*W-1:W] = 32'hC0200000;
    bus.req_valid = 2'b10;
    push(1'b1, 2'b10, F2_0, 32'hC0200000, 32'hC0A00000, 1'b0);
    @(negedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(n0, 100);
    check_eq("edge_done_cycle", rsp_cyc, c0 + TIMEOUT + 3);

    // Done in the ISSUE cycle is ignored; the next pulse completes it.
    @(negedge clk);
    c0 = cyc; n0 = rsp_count; fu_stuck = 1'b1; done_at = c0 + 1;
    bus.req_op[1:0] = 2'b01; bus.req_a[W-1:0] = F2_0; bus.req_b[W-1:0] = F1_0;
    bus.req_valid = 2'b01;
    push(1'b0, 2'b01, F2_0, F1_0, F1_0, 1'b0);
    @(negedge clk); #1;
    bus.req_valid = 2'b00;
    done_at = c0 + 4;
    wait_rsp(n0, 20);
    check_eq("issue_done_cycle", rsp_cyc, c0 + 5);

    // Operand changes after acceptance are invisible; ready held off through RESP.
    @(negedge clk);
    c0 = cyc; n0 = rsp_count; fu_stuck = 1'b0; fu_lat = 6;
    bus.req_op[3:2] = 2'b11; bus.req_a[2*W-1:W] = F3_0; bus.req_b[2*W-1:W] = F2_0;
    bus.req_valid = 2'b10;
    push(1'b1, 2'b11, F3_0, F2_0, F1_5, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      check_eq("stab_ready", bus.req_ready, 2'b00);
      if (i >= 2 && i <= 7) begin
        check_eq("stab_fu_a", bus.fu_a, F3_0);
        check_eq("stab_fu_op", bus.fu_op, 2'b11);
      end
      if (i == 3) begin
        bus.req_op[3:2] = 2'b00; bus.req_a[2*W-1:W] = F1_0;
        push(1'b1, 2'b00, F1_0, F2_0, F3_0, 1'b0);
      end
    end
    check_eq("stab_first_rsp", rsp_count, n0 + 1);
    @(negedge clk); #1;
    check_eq("stab_ready_after", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(n0 + 1, 20);

    // Reset during WAIT abandons the command.
    @(negedge clk);
    c0 = cyc; fu_stuck = 1'b1;
    bus.req_op[1:0] = 2'b01; bus.req_a[W-1:0] = F3_0; bus.req_b[W-1:0] = F1_0;
    bus.req_valid = 2'b01;
    push(1'b0, 2'b01, F3_0, F1_0, F2_0, 1'b0);
    @(negedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_fu_a", bus.fu_a, 0);
    check_eq("midrst_fu_op", bus.fu_op, 2'b00);
    check_eq("midrst_rsp_valid", bus.rsp_valid, 2'b00);
    sb.delete();
    @(negedge clk); #1;
    reset_n = 1'b1;
    n0 = rsp_count;
    done_at = cyc + 2;
    repeat (5) @(negedge clk);
    #1;
    check_eq("late_done_ignored", rsp_count, n0);

    @(negedge clk);
    c0 = cyc; fu_stuck = 1'b0; fu_lat = 2;
    bus.req_op[1:0] = 2'b00; bus.req_a[W-1:0] = F2_0; bus.req_b[W-1:0] = F1_0;
    bus.req_valid = 2'b01;
    push(1'b0, 2'b00, F2_0, F1_0, F3_0, 1'b0);
    @(negedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(n0, 20);
    check_eq("post_rst_cycle", rsp_cyc, c0 + 4);
    check_eq("sb_empty", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
